sync2d_hs_tx: RTL and testbench

- Source-side transmitter of a two-phase (toggle) req/ack clock-crossing handshake.
- Accepts a word on a valid/ready interface and drives a toggle request with stable data to the far domain.
- Waits for the far domain's returned acknowledge toggle, resynchronised internally by two flops, before accepting or launching the next word.
- Pairs with the destination-side synchronising receiver; all logic runs on the single source clock.

---
 rtl/sync2d_hs_tx.sv | 142 ++++++++++++++
 tb/tb_sync2d_hs_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync2d_hs_tx.sv
// sync2d_hs_tx: source side of a two-phase req/ack clock-crossing handshake.
// Takes a word on src_vld/src_rdy, toggles tx_req with stable tx_data, and
// waits for the far-domain tx_ack toggle (two-flop resynchronised).
// Ports: clk, clr_ (async active-low), src_vld/src_data/src_rdy (input
// stream), tx_req/tx_data/tx_ack (far domain), busy, err_clr, err[1:0]
// (bit0 ack timeout, bit1 spurious ack).
// Optional: define SYNC2D_HS_TX_SKID_EN to add a one-entry skid register.
module sync2d_hs_tx #(
    parameter int DW      = 8,
    parameter int TMO_CYC = 256,
    parameter int TMO_W   = 9
) (
    input  logic          clk,
    input  logic          clr_,
    input  logic          src_vld,
    input  logic [DW-1:0] src_data,
    output logic          src_rdy,
    output logic          tx_req,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ack,
    output logic          busy,
    input  logic          err_clr,
    output logic [1:0]    err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t            state, state_n;
    logic              ack_s1, ack_s2;
    logic              req_n;
    logic [DW-1:0]     data_n;
    logic [TMO_W-1:0]  tmo_cnt, cnt_n;
    logic [1:0]        err_set, err_n;
    logic              done, accept;
`ifdef SYNC2D_HS_TX_SKID_EN
    logic              skid_vld, skid_vld_n;
    logic [DW-1:0]     skid_data, skid_data_n;
`endif

    // Far end has echoed our current request phase.
    assign done = (ack_s2 == tx_req);
    assign busy = (state == WAIT_ACK);
`ifdef SYNC2D_HS_TX_SKID_EN
    assign src_rdy = ~skid_vld;
`else
    assign src_rdy = (state == IDLE);
`endif
    assign accept = src_vld & src_rdy;

    always_comb begin
        state_n = state;
        req_n   = tx_req;
        data_n  = tx_data;
        cnt_n   = tmo_cnt;
        err_set = 2'b00;
`ifdef SYNC2D_HS_TX_SKID_EN
        skid_vld_n  = skid_vld;
        skid_data_n = skid_data;
`endif
        unique case (state)
            IDLE: begin
                if (accept) begin
                    data_n  = src_data;
                    req_n   = ~tx_req;
                    cnt_n   = '0;
                    state_n = WAIT_ACK;
                end else if (!done) begin
                    // Ack phase moved with nothing outstanding.
                    err_set[1] = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (tmo_cnt != '1) cnt_n = tmo_cnt + 1'b1;
                // Equality (not >=) so a cleared timeout stays clear
                // until the next transfer restarts the count.
                if (TMO_CYC != 0 && tmo_cnt == TMO_LAST) err_set[0] = 1'b1;
`ifdef SYNC2D_HS_TX_SKID_EN
                if (done) begin
                    if (skid_vld) begin
                        data_n     = skid_data;
                        req_n      = ~tx_req;
                        cnt_n      = '0;
                        skid_vld_n = 1'b0;
                    end else if (accept) begin
                        data_n = src_data;
                        req_n  = ~tx_req;
                        cnt_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (accept) begin
                    skid_vld_n  = 1'b1;
                    skid_data_n = src_data;
                end
`else
                if (done) state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        // A new error in the same cycle wins over the clear.
        err_n = (err_clr ? 2'b00 : err) | err_set;
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state   <= IDLE;
            ack_s1  <= 1'b0;
            ack_s2  <= 1'b0;
            tx_req  <= 1'b0;
            tx_data <= '0;
            tmo_cnt <= '0;
            err     <= 2'b00;
        end else begin
            state   <= state_n;
            ack_s1  <= tx_ack;
            ack_s2  <= ack_s1;
            tx_req  <= req_n;
            tx_data <= data_n;
            tmo_cnt <= cnt_n;
            err     <= err_n;
        end
    end

`ifdef SYNC2D_HS_TX_SKID_EN
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else begin
            skid_vld  <= skid_vld_n;
            skid_data <= skid_data_n;
        end
    end
`endif

endmodule

// File: tb/tb_sync2d_hs_tx.sv
// tb_sync2d_hs_tx: directed bench for sync2d_hs_tx with a scoreboard of
// launched words checked by a far-end monitor on every tx_req toggle.
module tb_sync2d_hs_tx;

    typedef struct {
        logic       req;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       clr_;
    logic       src_vld;
    logic [7:0] src_data;
    logic       src_rdy;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       busy;
    logic       err_clr;
    logic [1:0] err;

    logic       man_ack;
    logic       auto_ack;
    logic       far_auto;
    logic       exp_req;
    logic       r1;
    int         total;
    int         bad;
    exp_t       sbq[$];

    assign tx_ack = far_auto ? auto_ack : man_ack;

    sync2d_hs_tx #(.DW(8), .TMO_CYC(8), .TMO_W(4)) dut (
        .clk(clk),
        .clr_(clr_),
        .src_vld(src_vld),
        .src_data(src_data),
        .src_rdy(src_rdy),
        .tx_req(tx_req),
        .tx_data(tx_data),
        .tx_ack(tx_ack),
        .busy(busy),
        .err_clr(err_clr),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        exp_t e;
        int   n;
        n        = 0;
        src_vld  = 1'b1;
        src_data = d;
        exp_req  = ~exp_req;
        e.req    = exp_req;
        e.data   = d;
        sbq.push_back(e);
        while (!src_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {31'd0, src_rdy}, 1);
        tick();
        src_vld = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, busy}, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Far-end model: pops the scoreboard on every request toggle and,
    // in auto mode, echoes the phase back four cycles later.
    initial begin
        logic last_req;
        int   cd;
        exp_t e;
        last_req = 1'b0;
        cd       = 0;
        auto_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!clr_) begin
                last_req = 1'b0;
                cd       = 0;
                auto_ack = 1'b0;
                continue;
            end
            if (!far_auto) auto_ack = man_ack;
            if (tx_req != last_req) begin
                last_req = tx_req;
                cd       = 4;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got %0h expected none", tx_data);
                end else begin
                    e = sbq.pop_front();
                    chk("word_req", {31'd0, tx_req}, {31'd0, e.req});
                    chk("word_data", {24'd0, tx_data}, {24'd0, e.data});
                end
            end else if (far_auto && cd > 0) begin
                cd--;
                if (cd == 0) auto_ack = last_req;
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        clr_     = 1'b0;
        src_vld  = 1'b0;
        src_data = 8'h00;
        err_clr  = 1'b0;
        man_ack  = 1'b0;
        far_auto = 1'b0;
        exp_req  = 1'b0;
        r1       = 1'b0;
        repeat (3) tick();
        clr_ = 1'b1;
        tick();

        // Reset state
        chk("rst_rdy", {31'd0, src_rdy}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req", {31'd0, tx_req}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_err", {30'd0, err}, 0);

        // Single transfer, ack returned by hand
        send(8'hA5);
        chk("s1_req", {31'd0, tx_req}, 1);
        chk("s1_data", {24'd0, tx_data}, 32'hA5);
        chk("s1_busy", {31'd0, busy}, 1);
`ifdef SYNC2D_HS_TX_SKID_EN
        chk("s1_rdy", {31'd0, src_rdy}, 1);
`else
        chk("s1_rdy", {31'd0, src_rdy}, 0);
`endif
        man_ack = 1'b1;
        tick();
        tick();
        chk("s1_busy_2", {31'd0, busy}, 1);
        tick();
        chk("s1_busy_3", {31'd0, busy}, 0);
        chk("s1_rdy_3", {31'd0, src_rdy}, 1);
        tick();
        chk("s1_rdy_4", {31'd0, src_rdy}, 1);
        chk("s1_err", {30'd0, err}, 0);

        // Back-to-back words with automatic far end
        far_auto = 1'b1;
        send(8'h11);
        send(8'h22);
        wait_idle("b2b_idle");
        chk("b2b_req", {31'd0, tx_req}, 1);
        chk("b2b_data", {24'd0, tx_data}, 32'h22);
        chk("b2b_err", {30'd0, err}, 0);
        man_ack  = exp_req;
        far_auto = 1'b0;
        tick();

        // Ack timeout
        send(8'h33);
        repeat (7) tick();
        chk("tmo_err_7", {30'd0, err}, 0);
        tick();
        chk("tmo_err_8", {30'd0, err}, 1);
        chk("tmo_busy", {31'd0, busy}, 1);
        pulse_clr();
        chk("tmo_clr", {30'd0, err}, 0);
        repeat (20) tick();
        chk("tmo_stay_clr", {30'd0, err}, 0);
        chk("tmo_busy_2", {31'd0, busy}, 1);
        chk("tmo_data", {24'd0, tx_data}, 32'h33);
        man_ack = exp_req;
        wait_idle("tmo_idle");
        send(8'h44);
        repeat (8) tick();
        chk("tmo2_err", {30'd0, err}, 1);
        man_ack = exp_req;
        wait_idle("tmo2_idle");
        pulse_clr();
        chk("tmo2_clr", {30'd0, err}, 0);

        // Spurious ack while idle
        man_ack = ~exp_req;
        tick();
        tick();
        chk("sp_err_2", {30'd0, err}, 0);
        tick();
        chk("sp_err_3", {30'd0, err}, 2);
        chk("sp_req", {31'd0, tx_req}, {31'd0, exp_req});
        chk("sp_busy", {31'd0, busy}, 0);
        man_ack = exp_req;
        repeat (3) tick();
        pulse_clr();
        chk("sp_clr", {30'd0, err}, 0);

        // Reset in the middle of a transfer
        send(8'h55);
        tick();
        chk("mr_busy", {31'd0, busy}, 1);
        #2;
        clr_    = 1'b0;
        man_ack = 1'b0;
        exp_req = 1'b0;
        #1;
        chk("mr_req", {31'd0, tx_req}, 0);
        chk("mr_data", {24'd0, tx_data}, 0);
        chk("mr_busy_0", {31'd0, busy}, 0);
        chk("mr_rdy", {31'd0, src_rdy}, 1);
        tick();
        tick();
        clr_ = 1'b1;
        tick();
        send(8'h66);
        chk("mr2_req", {31'd0, tx_req}, 1);
        chk("mr2_data", {24'd0, tx_data}, 32'h66);
        chk("mr2_busy", {31'd0, busy}, 1);
        man_ack = 1'b1;
        tick();
        tick();
        chk("mr2_busy_2", {31'd0, busy}, 1);
        tick();
        chk("mr2_busy_3", {31'd0, busy}, 0);
        chk("mr2_err", {30'd0, err}, 0);

        // Second word offered during a transfer
        send(8'h01);
        r1 = exp_req;
`ifdef SYNC2D_HS_TX_SKID_EN
        src_vld  = 1'b1;
        src_data = 8'h02;
        exp_req  = ~exp_req;
        sbq.push_back('{exp_req, 8'h02});
        chk("sk_rdy_0", {31'd0, src_rdy}, 1);
        tick();
        src_vld = 1'b0;
        chk("sk_rdy_1", {31'd0, src_rdy}, 0);
        man_ack = r1;
        tick();
        tick();
        chk("sk_data_a", {24'd0, tx_data}, 32'h01);
        chk("sk_req_a", {31'd0, tx_req}, {31'd0, r1});
        tick();
        chk("sk_data_b", {24'd0, tx_data}, 32'h02);
        chk("sk_req_b", {31'd0, tx_req}, {31'd0, ~r1});
        chk("sk_busy", {31'd0, busy}, 1);
        chk("sk_rdy_2", {31'd0, src_rdy}, 1);
        man_ack = exp_req;
        wait_idle("sk_idle");
`else
        src_vld  = 1'b1;
        src_data = 8'h02;
        chk("ns_rdy_0", {31'd0, src_rdy}, 0);
        man_ack = r1;
        tick();
        tick();
        chk("ns_rdy_1", {31'd0, src_rdy}, 0);
        chk("ns_data_a", {24'd0, tx_data}, 32'h01);
        tick();
        chk("ns_busy", {31'd0, busy}, 0);
        chk("ns_rdy_2", {31'd0, src_rdy}, 1);
        chk("ns_data_b", {24'd0, tx_data}, 32'h01);
        exp_req = ~exp_req;
        sbq.push_back('{exp_req, 8'h02});
        tick();
        src_vld = 1'b0;
        chk("ns_data_c", {24'd0, tx_data}, 32'h02);
        chk("ns_req_c", {31'd0, tx_req}, {31'd0, exp_req});
        chk("ns_busy_c", {31'd0, busy}, 1);
        man_ack = exp_req;
        wait_idle("ns_idle");
`endif
        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);
        chk("end_err", {30'd0, err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
